stream_demux: RTL
=================

Name: stream_demux

Overview:
- Two-way demultiplexer. It is the fan-out counterpart of the datapath 2:1 select: one producer stream is steered by a per-beat select bit into one of two consumer streams.
- Each consumer has its own small registered FIFO, so a stalled consumer does not block traffic bound for the other once that beat is accepted.
- Sits between the result/writeback producer and two downstream consumers, e.g. register-file write path and memory-store path.

Parameters:
- WIDTH, 32, data width in bits. Data is treated as signed and passed through unmodified.
- DEPTH, 2, entries per output FIFO. Must be a power of two and >= 2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- in_valid  input  1  producer has a beat
- in_ready  output  1  beat accepted this cycle when in_valid && in_ready
- in_select  input  1  target: 0 -> out0, 1 -> out1
- in_data  input  signed WIDTH  payload
- out0_valid  output  1  out0 FIFO non-empty
- out0_ready  input  1  consumer 0 pops
- out0_data  output  signed WIDTH  out0 FIFO head
- out1_valid  output  1  out1 FIFO non-empty
- out1_ready  input  1  consumer 1 pops
- out1_data  output  signed WIDTH  out1 FIFO head

Behaviour:
- Reset is synchronous. On the first clk edge with reset=1:
  - all pointers and counts clear to 0;
  - out0_valid and out1_valid go to 0;
  - out*_data go to 0 (the head register is cleared).
- in_ready is 0 while reset is asserted.
- in_ready is combinational: in_ready = !reset && (in_select ? !full1 : !full0).
  - Full is evaluated before any same-cycle pop. There is no pass-through when full.
  - in_ready depends only on in_select and FIFO state, never on in_valid.
- Accept: when in_valid && in_ready, in_data is written to the tail of the selected FIFO at the clk edge.
- Latency: a beat accepted in cycle N is visible as outX_valid=1 / outX_data in cycle N+1 if that FIFO was empty. There is no combinational in-to-out path.
- Pop: when outX_valid && outX_ready, the head advances at the clk edge. outX_ready while outX_valid=0 has no effect.
- Each FIFO keeps rd_ptr, wr_ptr and a count field of clog2(DEPTH)+1 bits.
  - Pointers wrap modulo DEPTH.
  - full = (count == DEPTH); empty = (count == 0).
- Simultaneous push and pop on the same non-full, non-empty FIFO: count is unchanged and both pointers advance.
- Simultaneous push and pop on an empty FIFO: not possible, because pop requires valid.
- A push to one FIFO and a pop from the other are independent.
- Ordering:
  - FIFO order is preserved within each output.
  - No ordering relation is guaranteed between out0 and out1.
- Back-pressure is per beat. If the selected FIFO is full, the producer must hold in_valid, in_select and in_data stable until accepted. The bench asserts this.
- Reset mid-operation: all queued beats are discarded and no partial beat is emitted. The cycle after reset deasserts, both outputs are invalid and in_ready follows the empty FIFOs.
- Overflow and underflow are impossible by construction. Assertions check count <= DEPTH and count >= 0.

Optional Feature:
- Macro: STREAM_DEMUX_STATS_EN.
- When defined, three 16-bit output ports are added:
  - stat_cnt0: beats accepted to out0;
  - stat_cnt1: beats accepted to out1;
  - stat_stall: cycles with in_valid && !in_ready.
- All three counters saturate at 16'hFFFF and clear on reset.
- When not defined, these ports and their counters are absent, and the rest of the behaviour is identical.

Decomposition:
- Package stream_demux_pkg holds:
  - constant DEFAULT_DEPTH = 2;
  - constant STAT_W = 16;
  - function clog2.
- Sub-module stream_demux_fifo (WIDTH, DEPTH):
  - inputs push, pop, wdata;
  - outputs rdata, full, empty;
  - instantiated twice.
- Steering logic and stats stay in the top level.

Test Plan:
- Reset, then a single beat in_select=0, in_data=32'sd-5 with out0_ready=1 -> out0_valid=1 one cycle after accept with out0_data=-5; out1_valid stays 0.
- Hold out1_ready=0 and send 3 beats with in_select=1 (values 1, 2, 3), DEPTH=2 -> beats 1 and 2 accepted; in_ready=0 while presenting 3. Then assert out1_ready -> outputs 1, 2, 3 in order, with 3 accepted the cycle after the first pop.
- out1 full and stalled; send in_select=0 beat 7 -> accepted immediately; out0_data=7 the next cycle while out1 stays full.
- Streaming: out0 with out0_ready=1 continuously, 10 back-to-back beats 0..9 -> in_ready stays 1 and out0 delivers 0..9 one per cycle, exercising pointer wrap 5 times.
- Fill both FIFOs, assert reset for one cycle mid-stream -> next cycle out0_valid=out1_valid=0 and in_ready=1; no stale data after new beats.
- With STREAM_DEMUX_STATS_EN: 4 beats to out0, 2 to out1, 3 stall cycles -> stat_cnt0=4, stat_cnt1=2, stat_stall=3. Force 70000 stall cycles -> stat_stall=16'hFFFF.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// -----------------------------------------------------------------------------
// stream_demux_pkg
// Shared constants and helpers for the two-way stream demultiplexer.
//   DEFAULT_DEPTH : default entries per output FIFO (power of two, >= 2)
//   STAT_W        : width of the optional statistics counters
//   clog2()       : ceiling log2, usable in constant expressions
// -----------------------------------------------------------------------------
package stream_demux_pkg;

  localparam int DEFAULT_DEPTH = 2;
  localparam int STAT_W        = 16;

  // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(4) = 2.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_demux_fifo.sv
// -----------------------------------------------------------------------------
// stream_demux_fifo
// Small synchronous FIFO used on each demux output. Reads come straight from
// registered storage, so there is no combinational wdata -> rdata path.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   push       : write wdata at the tail (caller guarantees !full)
//   pop        : advance the head (caller guarantees !empty)
//   wdata      : signed WIDTH-bit payload in
//   rdata      : signed WIDTH-bit head entry, 0 while empty
//   full/empty : occupancy flags, evaluated before any same-cycle push/pop
// DEPTH must be a power of two and >= 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module stream_demux_fifo
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic signed [WIDTH-1:0] wdata,
  output logic signed [WIDTH-1:0] rdata,
  output logic                    full,
  output logic                    empty
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic signed [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           wr_ptr;
  logic [CW-1:0]           count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // The head reads as zero while empty, which is what makes the output data
  // clear on reset without having to clear every storage entry.
  assign rdata = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others; blocking here would create
  // order-dependent simulation that does not match the synthesized flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      // Push and pop together leave the count unchanged.
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; validity is tracked by
  // count alone, and leaving the array out of reset lets it map to plain
  // registers/RAM without a reset tree.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    count <= CW'(DEPTH));
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(pop && empty));

endmodule

// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
// Two-way stream demultiplexer: one producer stream is steered by a per-beat
// select bit into one of two consumer streams, each buffered by its own FIFO so
// a stalled consumer only blocks beats addressed to it.
//   clk, reset             : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready      : producer handshake (in_ready is combinational and
//                            depends only on in_select and FIFO state)
//   in_select              : 0 -> out0, 1 -> out1
//   in_data                : signed WIDTH-bit payload, passed through unmodified
//   out0_valid/ready/data  : consumer 0 stream (FIFO head)
//   out1_valid/ready/data  : consumer 1 stream (FIFO head)
// Optional build macro STREAM_DEMUX_STATS_EN adds saturating 16-bit counters:
//   stat_cnt0  : beats accepted to out0
//   stat_cnt1  : beats accepted to out1
//   stat_stall : cycles with in_valid && !in_ready
// -----------------------------------------------------------------------------
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_select,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out0_valid,
  input  logic                    out0_ready,
  output logic signed [WIDTH-1:0] out0_data,
  output logic                    out1_valid,
  input  logic                    out1_ready,
  output logic signed [WIDTH-1:0] out1_data
`ifdef STREAM_DEMUX_STATS_EN
  ,
  output logic [STAT_W-1:0]       stat_cnt0,
  output logic [STAT_W-1:0]       stat_cnt1,
  output logic [STAT_W-1:0]       stat_stall
`endif
);

  logic full0, full1;
  logic empty0, empty1;
  logic accept;
  logic push0, push1;
  logic pop0, pop1;

  // Full is taken before any same-cycle pop, so a full FIFO never passes a
  // beat through even if its consumer is draining this cycle.
  assign in_ready = !reset && (in_select ? !full1 : !full0);
  assign accept   = in_valid && in_ready;
  assign push0    = accept && !in_select;
  assign push1    = accept &&  in_select;

  assign out0_valid = !empty0;
  assign out1_valid = !empty1;
  assign pop0       = out0_valid && out0_ready;
  assign pop1       = out1_valid && out1_ready;

  stream_demux_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk   (clk),
    .reset (reset),
    .push  (push0),
    .pop   (pop0),
    .wdata (in_data),
    .rdata (out0_data),
    .full  (full0),
    .empty (empty0)
  );

  stream_demux_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk   (clk),
    .reset (reset),
    .push  (push1),
    .pop   (pop1),
    .wdata (in_data),
    .rdata (out1_data),
    .full  (full1),
    .empty (empty1)
  );

`ifdef STREAM_DEMUX_STATS_EN
  logic stall;
  assign stall = in_valid && !in_ready;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_cnt0  <= '0;
      stat_cnt1  <= '0;
      stat_stall <= '0;
    end else begin
      if (push0 && (stat_cnt0  != '1)) stat_cnt0  <= stat_cnt0  + STAT_W'(1);
      if (push1 && (stat_cnt1  != '1)) stat_cnt1  <= stat_cnt1  + STAT_W'(1);
      if (stall && (stat_stall != '1)) stat_stall <= stat_stall + STAT_W'(1);
    end
  end
`endif

endmodule
